// File: rtl/sigma_delta_ctrl_if.sv
// Pixel stream, RAM strobes, update-unit controls and frame status of the sigma-delta sequencer.
// master = the sequencer, slave = the camera/RAM/update-unit side.
interface sigma_delta_ctrl_if #(
  parameter int unsigned ADDR_W = 19
);
  logic              start;
  logic              init_req;
  logic              pix_valid;
  logic              pix_ready;
  logic [7:0]        pix_data;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic              sd_enable;
  logic              sd_wr_background;
  logic [7:0]        sd_curr_pixel;
  logic              sd_motion;
  logic              motion_valid;
  logic              motion_bit;
  logic [ADDR_W-1:0] motion_addr;
  logic [ADDR_W:0]   motion_count;
  logic              frame_done;
  logic              busy;

  modport master (
    input  start, init_req, pix_valid, pix_data, sd_motion,
    output pix_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, sd_enable,
           sd_wr_background, sd_curr_pixel, motion_valid, motion_bit, motion_addr,
           motion_count, frame_done, busy
  );

  modport slave (
    output start, init_req, pix_valid, pix_data, sd_motion,
    input  pix_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, sd_enable,
           sd_wr_background, sd_curr_pixel, motion_valid, motion_bit, motion_addr,
           motion_count, frame_done, busy
  );
endinterface

// File: rtl/sigma_delta_ctrl.sv
// Frame sequencer for the sigma-delta background/variance update: read at accept,
// update one cycle later, write-back two cycles after accept, per-frame motion count.
module sigma_delta_ctrl #(
  parameter int unsigned IMG_W       = 640,
  parameter int unsigned IMG_H       = 480,
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned INIT_FRAMES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  sigma_delta_ctrl_if.master  io_bus
);

  localparam int unsigned       NPix    = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LastPix = ADDR_W'(NPix - 1);
  localparam logic [ADDR_W:0]   AccMax  = '1;
  localparam logic [3:0]        InitMax = 4'(INIT_FRAMES);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            r_state, w_state_d;
  logic              r_drain, w_drain_d;
  logic [ADDR_W-1:0] r_pix_cnt;
  logic [3:0]        r_init_cnt;
  logic              r_init_mode;
  logic              r_s1_valid;
  logic [7:0]        r_s1_pix;
  logic [ADDR_W-1:0] r_s1_addr;
  logic              r_s2_valid;
  logic [ADDR_W-1:0] r_s2_addr;
  logic              r_s2_motion;
  logic [ADDR_W:0]   r_acc;
  logic [ADDR_W:0]   r_motion_count;

  logic       w_frame_start;
  logic       w_accept;
  logic       w_pix_ready;
  logic       w_run;
  logic       w_frame_done;
  logic       w_s1_motion;
  logic [3:0] w_init_cnt_eff;
  logic       w_init_mode_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_drain <= w_drain_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_drain_d     = 1'b0;
    w_frame_start = 1'b0;
    w_accept      = 1'b0;
    w_pix_ready   = 1'b0;
    w_run         = 1'b0;
    w_frame_done  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_state_d     = StRun;
          w_frame_start = 1'b1;
        end
      end
      StRun: begin
        w_pix_ready = 1'b1;
        w_run       = 1'b1;
        w_accept    = io_bus.pix_valid;
        if (w_accept && (r_pix_cnt == LastPix)) w_state_d = StDrain;
      end
      StDrain: begin
        // Two cycles: lets the last pixel pass S1 and S2 before the frame closes.
        w_run     = 1'b1;
        w_drain_d = 1'b1;
        if (r_drain) w_state_d = StDone;
      end
      StDone: begin
        w_frame_done = 1'b1;
        w_state_d    = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_init_cnt_eff   = io_bus.init_req ? 4'd0 : r_init_cnt;
  assign w_init_mode_next = (w_init_cnt_eff < InitMax);
  // Init frames only seed the background, so their motion is meaningless.
  assign w_s1_motion      = r_s1_valid & io_bus.sd_motion & ~r_init_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt      <= '0;
      r_init_cnt     <= '0;
      r_init_mode    <= 1'b0;
      r_s1_valid     <= 1'b0;
      r_s1_pix       <= '0;
      r_s1_addr      <= '0;
      r_s2_valid     <= 1'b0;
      r_s2_addr      <= '0;
      r_s2_motion    <= 1'b0;
      r_acc          <= '0;
      r_motion_count <= '0;
    end else begin
      r_s1_valid  <= w_accept;
      r_s2_valid  <= r_s1_valid;
      r_s2_addr   <= r_s1_addr;
      r_s2_motion <= w_s1_motion;
      if (w_accept) begin
        r_pix_cnt <= (r_pix_cnt == LastPix) ? '0 : r_pix_cnt + 1'b1;
        r_s1_pix  <= io_bus.pix_data;
        r_s1_addr <= r_pix_cnt;
      end
      if (w_frame_start) begin
        r_pix_cnt   <= '0;
        r_acc       <= '0;
        r_init_mode <= w_init_mode_next;
        if (io_bus.init_req) r_init_cnt <= '0;
      end else if (w_s1_motion && (r_acc != AccMax)) begin
        r_acc <= r_acc + 1'b1;
      end
      if (w_frame_done) begin
        r_motion_count <= r_acc;
        if (r_init_cnt < InitMax) r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

  assign io_bus.pix_ready        = w_pix_ready;
  assign io_bus.mem_rd_en        = w_accept;
  assign io_bus.mem_rd_addr      = r_pix_cnt;
  assign io_bus.mem_wr_en        = r_s2_valid;
  assign io_bus.mem_wr_addr      = r_s2_addr;
  assign io_bus.sd_enable        = w_run;
  assign io_bus.sd_wr_background = w_run & r_init_mode;
  assign io_bus.sd_curr_pixel    = r_s1_pix;
  assign io_bus.motion_valid     = r_s2_valid;
  assign io_bus.motion_bit       = r_s2_motion;
  assign io_bus.motion_addr      = r_s2_addr;
  assign io_bus.motion_count     = r_motion_count;
  assign io_bus.frame_done       = w_frame_done;
  assign io_bus.busy             = (r_state != StIdle);

endmodule

// File: tb/tb_sigma_delta_ctrl.sv
// Scoreboard bench for sigma_delta_ctrl on a 4x2 frame: stimulus pushes expected write-backs,
// update-unit samples and frame completions; a negedge monitor pops and compares.
module tb_sigma_delta_ctrl;
  localparam int unsigned IMG_W       = 4;
  localparam int unsigned IMG_H       = 2;
  localparam int unsigned ADDR_W      = 3;
  localparam int unsigned INIT_FRAMES = 1;
  localparam int          NPIX        = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sigma_delta_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  sigma_delta_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .INIT_FRAMES(INIT_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io_bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {int addr; int mbit; int due;} wr_t;
  typedef struct {int pix; int bg; int due;} s1_t;
  typedef struct {int due; int cnt;} done_t;
  wr_t   wr_q[$];
  s1_t   s1_q[$];
  done_t done_q[$];

  // Environment model: RAM returns a cycle after the read; update unit flags motion per address.
  bit                mot[NPIX];
  logic              ram_v = 1'b0;
  logic [ADDR_W-1:0] ram_a = '0;
  always @(posedge clk) begin
    ram_v <= bus.mem_rd_en;
    ram_a <= bus.mem_rd_addr;
  end
  assign bus.sd_motion = ram_v & mot[ram_a];

  int en_lo = 1 << 30;
  int en_hi = -1;
  int cnt_due = -1;
  int cnt_exp = 0;
  int m_init_cnt = 0;

  always @(negedge clk) begin
    wr_t   w;
    s1_t   s;
    done_t d;
    if (rst_n) begin
      chk("sd_enable", bus.sd_enable, (cyc >= en_lo && cyc <= en_hi));
      chk("busy", bus.busy, (cyc >= en_lo && cyc <= en_hi + 1));
      if (s1_q.size() > 0 && s1_q[0].due < cyc) begin
        s = s1_q.pop_front();
        chk("s1_due", cyc, s.due);
      end
      if (s1_q.size() > 0 && s1_q[0].due == cyc) begin
        s = s1_q.pop_front();
        chk("sd_curr_pixel", bus.sd_curr_pixel, s.pix);
        chk("sd_wr_background", bus.sd_wr_background, s.bg);
      end
      if (bus.mem_wr_en) begin
        if (wr_q.size() == 0) chk("wr_queue", wr_q.size(), 1);
        else begin
          w = wr_q.pop_front();
          chk("wr_cycle", cyc, w.due);
          chk("mem_wr_addr", bus.mem_wr_addr, w.addr);
          chk("motion_addr", bus.motion_addr, w.addr);
          chk("motion_valid", bus.motion_valid, 1);
          chk("motion_bit", bus.motion_bit, w.mbit);
        end
      end else begin
        chk("motion_valid_idle", bus.motion_valid, 0);
        if (wr_q.size() > 0 && wr_q[0].due < cyc) begin
          w = wr_q.pop_front();
          chk("wr_due", cyc, w.due);
        end
      end
      if (bus.frame_done) begin
        if (done_q.size() == 0) chk("done_queue", done_q.size(), 1);
        else begin
          d = done_q.pop_front();
          chk("frame_done_cycle", cyc, d.due);
          cnt_due = cyc + 1;
          cnt_exp = d.cnt;
        end
      end else if (done_q.size() > 0 && done_q[0].due < cyc) begin
        d = done_q.pop_front();
        chk("frame_done_due", cyc, d.due);
      end
      if (cyc == cnt_due) chk("motion_count", bus.motion_count, cnt_exp);
    end
  end

  task automatic zero_check();
    chk("z_pix_ready", bus.pix_ready, 0);
    chk("z_mem_rd_en", bus.mem_rd_en, 0);
    chk("z_mem_rd_addr", bus.mem_rd_addr, 0);
    chk("z_mem_wr_en", bus.mem_wr_en, 0);
    chk("z_mem_wr_addr", bus.mem_wr_addr, 0);
    chk("z_sd_enable", bus.sd_enable, 0);
    chk("z_sd_wr_background", bus.sd_wr_background, 0);
    chk("z_sd_curr_pixel", bus.sd_curr_pixel, 0);
    chk("z_motion_valid", bus.motion_valid, 0);
    chk("z_motion_bit", bus.motion_bit, 0);
    chk("z_motion_addr", bus.motion_addr, 0);
    chk("z_motion_count", bus.motion_count, 0);
    chk("z_frame_done", bus.frame_done, 0);
    chk("z_busy", bus.busy, 0);
  endtask

  // mode 0: pixel 50, random motion; 1: motion at 2,5,6; 2: 1-in-3 valid gaps; 3: random data.
  task automatic frame(input bit ireq, input int mode, input int abort_px, input bit poke);
    int  s;
    int  p;
    int  guard;
    int  last;
    bit  v;
    bit  f_init;
    int  exp_cnt;
    logic [7:0] px;
    s = cyc;
    bus.start = 1'b1;
    bus.init_req = ireq;
    if (ireq) m_init_cnt = 0;
    f_init = (m_init_cnt < INIT_FRAMES);
    exp_cnt = 0;
    for (int i = 0; i < NPIX; i++) begin
      mot[i] = (mode == 1) ? (i == 2 || i == 5 || i == 6) : 1'($urandom_range(0, 1));
      if (mot[i] && !f_init) exp_cnt++;
    end
    en_lo = s + 1;
    en_hi = 1 << 30;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.init_req = 1'b0;
    p = 0;
    guard = 0;
    last = -1;
    while (p < NPIX) begin
      v = (mode == 2) ? ((p == 0) || ($urandom_range(0, 2) == 0)) : 1'b1;
      px = (mode == 0) ? 8'd50 : 8'($urandom);
      bus.pix_valid = v;
      bus.pix_data = px;
      bus.start = poke;
      bus.init_req = poke;
      @(negedge clk);
      if (v && bus.pix_ready) begin
        if (p == 0) chk("first_accept_cycle", cyc, s + 1);
        chk("mem_rd_en", bus.mem_rd_en, 1);
        chk("mem_rd_addr", bus.mem_rd_addr, p);
        wr_q.push_back('{addr: p, mbit: int'(mot[p] && !f_init), due: cyc + 2});
        s1_q.push_back('{pix: int'(px), bg: int'(f_init), due: cyc + 1});
        if (p == NPIX - 1) begin
          last = cyc;
          en_hi = cyc + 2;
          done_q.push_back('{due: cyc + 3, cnt: exp_cnt});
        end
        p++;
        guard = 0;
        if (p == abort_px + 1) begin
          #2;
          rst_n = 1'b0;
          #1;
          zero_check();
          wr_q.delete();
          s1_q.delete();
          done_q.delete();
          en_lo = 1 << 30;
          en_hi = -1;
          m_init_cnt = 0;
          bus.pix_valid = 1'b0;
          bus.start = 1'b0;
          bus.init_req = 1'b0;
          repeat (2) @(posedge clk);
          #1;
          rst_n = 1'b1;
          repeat (4) @(posedge clk);
          #1;
          return;
        end
      end else begin
        if (!v) chk("mem_rd_idle", bus.mem_rd_en, 0);
        guard++;
        if (guard > 100) begin
          chk("accept_timeout", p, NPIX);
          break;
        end
      end
      @(posedge clk); #1;
    end
    bus.pix_valid = 1'b0;
    bus.start = poke;
    bus.init_req = poke;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.init_req = 1'b0;
    @(posedge clk); #1;
    if (m_init_cnt < INIT_FRAMES) m_init_cnt++;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.init_req = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data = '0;
    repeat (2) @(posedge clk);
    #1;
    zero_check();
    rst_n = 1'b1;
    @(posedge clk); #1;
    frame(1'b0, 0, -1, 1'b0);
    frame(1'b0, 1, -1, 1'b0);
    frame(1'b0, 2, -1, 1'b1);
    frame(1'b1, 3, -1, 1'b0);
    frame(1'b0, 3, -1, 1'b0);
    frame(1'b0, 3, 3, 1'b0);
    frame(1'b0, 3, -1, 1'b0);
    frame(1'b0, 2, -1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("wr_q_drained", wr_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/sigma_delta_ctrl.md
Name: sigma_delta_ctrl

Overview:
- Frame-level sequencer for the per-pixel sigma-delta background/variance update datapath.
- Accepts a raster pixel stream with a valid/ready handshake and generates background/variance memory read/write addresses.
- Drives the update unit's enable and write-background controls, aligns its 1-cycle registered result with write-back, and accumulates a per-frame motion pixel count.
- Sits between the camera pixel stream and the background/variance RAM plus update unit.

Parameters:
- IMG_W, 640, pixels per line.
- IMG_H, 480, lines per frame; IMG_W*IMG_H must be >= 3.
- ADDR_W, 19, pixel address width; must hold IMG_W*IMG_H-1.
- INIT_FRAMES, 1, frames after reset or init_req run in write-background mode; range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start pulse; sampled only in IDLE
- init_req  in  1  re-arm init mode; sampled with start in IDLE
- pix_valid  in  1  stream pixel valid
- pix_ready  out  1  stream ready
- pix_data  in  8  stream pixel
- mem_rd_en  out  1  background/variance RAM read strobe; data returns next cycle
- mem_rd_addr  out  ADDR_W  read address
- mem_wr_en  out  1  write-back strobe; write data comes straight from the update unit outputs
- mem_wr_addr  out  ADDR_W  write address
- sd_enable  out  1  update unit enable
- sd_wr_background  out  1  update unit init-mode select
- sd_curr_pixel  out  8  pixel presented to the update unit
- sd_motion  in  1  combinational motion flag from the update unit
- motion_valid  out  1  per-pixel motion result strobe
- motion_bit  out  1  motion result
- motion_addr  out  ADDR_W  pixel address of the motion result
- motion_count  out  ADDR_W+1  motion pixels in the last completed frame
- frame_done  out  1  one-cycle pulse at end of frame
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0 and state is IDLE.
  - Pixel counter, pipeline valids and motion accumulator are 0.
  - init_cnt is 0, so init mode is active.
  - Reset asserted mid-frame aborts the frame: no further memory writes and no frame_done pulse.
- State machine: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE -> RUN: on start=1. This clears pix_cnt and the motion accumulator. If init_req=1, init_cnt is cleared. start in any other state is ignored.
  - RUN: pix_ready=1. Accept means pix_valid & pix_ready. After the accept at pix_cnt=IMG_W*IMG_H-1, move to DRAIN.
  - DRAIN: lasts exactly 2 cycles. pix_ready=0.
  - DONE: lasts 1 cycle. frame_done=1. motion_count is loaded from the accumulator. init_cnt increments, saturating at INIT_FRAMES. Then return to IDLE.
- init_mode = (init_cnt < INIT_FRAMES); it is latched at frame start and held for the whole frame.
- sd_enable = 1 in RUN and DRAIN, 0 otherwise. It is held high through stall bubbles because the update unit clears its outputs when disabled.
- Pipeline (accept at cycle t):
  - S0, cycle t: mem_rd_en=1 and mem_rd_addr=pix_cnt, both combinational from the accept. pix_data, pix_cnt and valid are registered into stage 1. pix_cnt increments.
  - S1, cycle t+1: sd_curr_pixel = stage-1 pixel (register output). sd_wr_background = init_mode. RAM data feeds the update unit.
    - motion_bit_next = sd_motion & ~init_mode; it is forced to 0 during init frames.
    - Stage-1 valid, address and motion are registered into stage 2.
    - If the stage-1 motion is 1, the accumulator increments.
  - S2, cycle t+2: mem_wr_en = stage-2 valid and mem_wr_addr = stage-2 address. motion_valid, motion_bit and motion_addr are driven from stage 2.
  - Latency from accept to write-back is 2 cycles.
- Stalls (pix_valid=0 in RUN): bubbles propagate as valid=0. No read, no write and no motion_valid are produced for a bubble. sd_curr_pixel holds its last value.
- Ordering and counts:
  - Addresses within a frame are strictly increasing, so there is no read-after-write hazard given N >= 3.
  - The accumulator saturates at 2^(ADDR_W+1)-1.
  - motion_count holds its value until the next DONE.

Test Plan:
- Reset then start with INIT_FRAMES=1 and a 4x2 frame of pix_data=8'd50, continuous valid:
  - mem_wr_en pulses at addresses 0..7, each 2 cycles after its accept.
  - sd_wr_background=1 and motion_bit=0 throughout.
  - frame_done pulses 3 cycles after the last accept; motion_count=0.
- Second frame where sd_motion is driven 1 for addresses 2, 5 and 6:
  - sd_wr_background=0.
  - motion_bit=1 at exactly motion_addr 2, 5 and 6.
  - motion_count=3 after frame_done.
- Random pix_valid gaps (for example 1-on/2-off):
  - Write and motion addresses remain 0..7 in order with no duplicates.
  - sd_enable stays 1 throughout RUN and DRAIN.
- start pulsed during RUN and DRAIN is ignored, and pixel counting is unaffected. start with init_req=1 in IDLE makes the next frame an init frame again.
- rst_n asserted at pixel 3 of a frame:
  - All outputs are 0 immediately and no frame_done occurs.
  - The next frame after start runs in init mode.
- Back-to-back frames, with start asserted on the cycle after DONE: the second frame begins and pixel 0 is accepted in the next cycle.
